// File: rtl/store_buffer.sv
// Word-store FIFO between MEM stage and data memory.
// Drains when the port is free; forwards the youngest buffered word to loads.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic                     ld_en,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     ld_hit,
    output logic [ADDR_W-1:0]        mem_A,
    output logic [DATA_W-1:0]        mem_WD,
    output logic                     mem_WE,
    input  logic [DATA_W-1:0]        mem_RD,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = ADDR_W - 2;

    logic [TW-1:0]     tag_q  [DEPTH];
    logic [TW-1:0]     tag_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              enq, deq;
    logic [PW-1:0]     idx;
    logic [DATA_W-1:0] fwd_data;
    logic              unused_lo;

    assign unused_lo = ^{st_addr[1:0], ld_addr[1:0]};

    always_comb begin
        st_ready = count_q < CW'(DEPTH);
        enq      = st_valid && st_ready;
        deq      = (count_q != '0) && !ld_en;
        mem_WE   = deq;
        mem_WD   = data_q[head_q];
        mem_A    = ld_en ? {ld_addr[ADDR_W-1:2], 2'b00}
                         : {tag_q[head_q], 2'b00};
        empty    = count_q == '0;
        count    = count_q;
    end

    // Scan oldest to youngest so the last match is the youngest.
    always_comb begin
        ld_hit   = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q && tag_q[idx] == ld_addr[ADDR_W-1:2]) begin
                ld_hit   = ld_en;
                fwd_data = data_q[idx];
            end
        end
        ld_data = ld_hit ? fwd_data : mem_RD;
    end

    always_comb begin
        tag_d  = tag_q;
        data_d = data_q;
        head_d = head_q;
        tail_d = tail_q;
        if (enq) begin
            tag_d[tail_q]  = st_addr[ADDR_W-1:2];
            data_d[tail_q] = st_data;
            tail_d         = tail_q + 1'b1;
        end
        if (deq) begin
            head_d = head_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule
